// File: rtl/chan_scan_hex.sv
// chan_scan_hex: N-channel selector, manual or auto-scanned channel, registered seven-segment digits.
// Define CHSCAN_CHIDX_EN to show the channel index on HEX1; otherwise HEX1 is held blank.
module chan_scan_hex #(
  parameter int N   = 4,
  parameter int W   = 2,
  parameter int DIV = 50_000_000,
  localparam int CW = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic            CLOCK_50,
  input  logic            RESET,
  input  logic [N*W-1:0]  DATA,
  input  logic [CW-1:0]   SEL,
  input  logic            AUTO,
  input  logic            HOLD,
  output logic [CW-1:0]   CH,
  output logic [6:0]      HEX0,
  output logic [6:0]      HEX1,
  output logic            STEP
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {MANUAL, SCAN, PAUSE} state_t;

  state_t        state;
  state_t        nxt;
  logic [PW-1:0] pre;
  logic [PW-1:0] pre_base;
  logic [CW-1:0] sel_clamped;
  logic [3:0]    cur_val;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    nxt = MANUAL;
    if (AUTO) nxt = HOLD ? PAUSE : SCAN;
  end

  // Leaving MANUAL always restarts the prescale count from zero.
  assign pre_base = (state == MANUAL) ? '0 : pre;

  generate
    if (N < (1 << CW)) begin : g_clamp
      assign sel_clamped = (SEL > CW'(N - 1)) ? CW'(N - 1) : SEL;
    end else begin : g_noclamp
      assign sel_clamped = SEL;
    end
  endgenerate

  assign cur_val = 4'(DATA[int'(CH) * W +: W]);

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state <= MANUAL;
      CH    <= '0;
      pre   <= '0;
      STEP  <= 1'b0;
      HEX0  <= '1;
    end else begin
      state <= nxt;
      STEP  <= 1'b0;
      HEX0  <= seg7(cur_val);
      case (nxt)
        MANUAL: begin
          CH  <= sel_clamped;
          pre <= '0;
        end
        SCAN: begin
          if (pre_base == PW'(DIV - 1)) begin
            pre  <= '0;
            CH   <= (CH == CW'(N - 1)) ? '0 : CH + CW'(1);
            STEP <= 1'b1;
          end else begin
            pre <= pre_base + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CHSCAN_CHIDX_EN
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) HEX1 <= '1;
    else       HEX1 <= seg7(4'(CH));
  end
`else
  assign HEX1 = '1;
`endif

endmodule

// File: tb/tb_chan_scan_hex.sv
// Bench for chan_scan_hex: directed scenarios plus random stimulus against a behavioural model,
// run on three builds (N=4/DIV=4, N=3/DIV=4, N=4/DIV=1) sharing the same inputs.
module tb_chan_scan_hex;

`ifdef CHSCAN_CHIDX_EN
  localparam bit CHIDX = 1'b1;
`else
  localparam bit CHIDX = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'b11_10_01_00;
  logic [1:0] sel = 2'd0;
  logic       auto = 1'b0;
  logic       hold = 1'b0;

  logic [1:0] d_ch[3];
  logic [6:0] d_h0[3];
  logic [6:0] d_h1[3];
  logic       d_st[3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  chan_scan_hex #(.N(4), .W(2), .DIV(4)) dut (
    .CLOCK_50(clk), .RESET(rst), .DATA(data), .SEL(sel), .AUTO(auto), .HOLD(hold),
    .CH(d_ch[0]), .HEX0(d_h0[0]), .HEX1(d_h1[0]), .STEP(d_st[0])
  );

  chan_scan_hex #(.N(3), .W(2), .DIV(4)) dut3 (
    .CLOCK_50(clk), .RESET(rst), .DATA(data[5:0]), .SEL(sel), .AUTO(auto), .HOLD(hold),
    .CH(d_ch[1]), .HEX0(d_h0[1]), .HEX1(d_h1[1]), .STEP(d_st[1])
  );

  chan_scan_hex #(.N(4), .W(2), .DIV(1)) dut1 (
    .CLOCK_50(clk), .RESET(rst), .DATA(data), .SEL(sel), .AUTO(auto), .HOLD(hold),
    .CH(d_ch[2]), .HEX0(d_h0[2]), .HEX1(d_h1[2]), .STEP(d_st[2])
  );

  logic [6:0] seg[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int nn[3] = '{4, 3, 4};
  int dv[3] = '{4, 4, 1};

  int         m_ch[3];
  int         m_pre[3];
  logic       m_st[3];
  logic [6:0] m_h0[3];
  logic [6:0] m_h1[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model updates on every edge, then the DUT outputs are compared 1ns later.
  always @(posedge clk or posedge rst) begin
    int v;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_ch[k] = 0; m_pre[k] = 0; m_st[k] = 1'b0; m_h0[k] = 7'h7F; m_h1[k] = 7'h7F;
      end else begin
        v = (int'(data) >> (2 * m_ch[k])) & 3;
        m_h0[k] = seg[v];
        m_h1[k] = CHIDX ? seg[m_ch[k]] : 7'h7F;
        m_st[k] = 1'b0;
        if (!auto) begin
          m_ch[k]  = (int'(sel) >= nn[k]) ? nn[k] - 1 : int'(sel);
          m_pre[k] = 0;
        end else if (!hold) begin
          m_pre[k]++;
          if (m_pre[k] == dv[k]) begin
            m_pre[k] = 0;
            m_ch[k]  = (m_ch[k] + 1) % nn[k];
            m_st[k]  = 1'b1;
          end
        end
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model ch[%0d]", k),   32'(d_ch[k]), 32'(m_ch[k]));
      chk($sformatf("model step[%0d]", k), 32'(d_st[k]), 32'(m_st[k]));
      chk($sformatf("model hex0[%0d]", k), 32'(d_h0[k]), 32'(m_h0[k]));
      chk($sformatf("model hex1[%0d]", k), 32'(d_h1[k]), 32'(m_h1[k]));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [6:0] h1exp(input logic [6:0] v);
    return CHIDX ? v : 7'h7F;
  endfunction

  initial begin
    // Reset state
    tick(); tick();
    chk("rst ch", 32'(d_ch[0]), 32'd0);
    chk("rst step", 32'(d_st[0]), 32'd0);
    chk("rst hex0", 32'(d_h0[0]), 32'h7F);
    chk("rst hex1", 32'(d_h1[0]), 32'h7F);
    rst = 1'b0;
    tick();
    chk("post-rst hex0", 32'(d_h0[0]), 32'h40);
    chk("post-rst hex1", 32'(d_h1[0]), 32'(h1exp(7'h40)));

    // Manual select with two-cycle latency to the display
    sel = 2'd2;
    tick();
    chk("sel ch", 32'(d_ch[0]), 32'd2);
    tick();
    chk("sel hex0", 32'(d_h0[0]), 32'h24);
    chk("sel hex1", 32'(d_h1[0]), 32'(h1exp(7'h24)));
    sel = 2'd3;
    tick(); tick();
    chk("sel3 hex0", 32'(d_h0[0]), 32'h30);
    chk("clamp n3 ch", 32'(d_ch[1]), 32'd2);

    // Auto-scan from CH=2 with wrap
    sel = 2'd2;
    tick(); tick();
    auto = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("scan step", 32'(d_st[0]), 32'((i % 4) == 0));
      chk("scan ch", 32'(d_ch[0]), 32'((2 + i / 4) % 4));
      chk("div1 step", 32'(d_st[2]), 32'd1);
      chk("div1 ch", 32'(d_ch[2]), 32'((2 + i) % 4));
    end

    // Hold two cycles after an advance
    tick(); tick();
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold ch", 32'(d_ch[0]), 32'd1);
      chk("hold step", 32'(d_st[0]), 32'd0);
    end
    hold = 1'b0;
    tick();
    chk("resume1 step", 32'(d_st[0]), 32'd0);
    chk("resume1 ch", 32'(d_ch[0]), 32'd1);
    tick();
    chk("resume2 step", 32'(d_st[0]), 32'd1);
    chk("resume2 ch", 32'(d_ch[0]), 32'd2);

    // Live data on the selected channel
    auto = 1'b0;
    sel = 2'd1;
    tick(); tick();
    chk("live hex0 before", 32'(d_h0[0]), 32'h79);
    data = 8'b11_10_10_00;
    tick();
    chk("live hex0 after", 32'(d_h0[0]), 32'h24);

    // Asynchronous reset in the middle of a scan
    data = 8'b11_10_01_00;
    auto = 1'b1;
    repeat (6) tick();
    #2 rst = 1'b1;
    #1;
    chk("async rst ch", 32'(d_ch[0]), 32'd0);
    chk("async rst step", 32'(d_st[0]), 32'd0);
    chk("async rst hex0", 32'(d_h0[0]), 32'h7F);
    chk("async rst hex1", 32'(d_h1[0]), 32'h7F);
    tick();
    rst = 1'b0;
    auto = 1'b0;
    sel = 2'd0;
    tick();
    chk("re-release hex0", 32'(d_h0[0]), 32'h40);

    // Random stimulus; the model process checks every cycle
    for (int i = 0; i < 3000; i++) begin
      tick();
      data = 8'($urandom);
      if ($urandom_range(0, 3) == 0) sel = 2'($urandom);
      if ($urandom_range(0, 39) == 0) auto = ~auto;
      if ($urandom_range(0, 7) == 0) hold = ~hold;
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chan_scan_hex.md
# chan_scan_hex

Parametrised N-channel, W-bit display selector with registered seven-segment output. It is the sequential successor of the switch-driven 4×2-bit mux-to-HEX path: the displayed channel is either chosen manually or auto-scanned at a programmable rate, with hold and a step strobe. It sits between board switch/data inputs and the HEX0/HEX1 digit drivers.

## Interface
Parameters:
- N, 4: channel count, 2..16.
- W, 2: bits per channel, 1..4; values are zero-extended to 4 bits before decode.
- DIV, 50_000_000: clock cycles per auto-scan step, ≥1.
- CW (localparam) = max(1, clog2(N)).

Ports:
- CLOCK_50  in  1  clock; all state updates on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- DATA  in  N*W  packed channel data; channel k occupies DATA[k*W +: W].
- SEL  in  CW  manual channel select.
- AUTO  in  1  1 = auto-scan mode, 0 = manual mode.
- HOLD  in  1  freezes auto-scan; ignored when AUTO=0.
- CH  out  CW  currently selected channel (register).
- HEX0  out  7  active-low digit for the selected channel's value; bit6=g … bit0=a.
- HEX1  out  7  active-low digit for CH.
- STEP  out  1  one-cycle pulse on each auto-scan advance.

## Operation
- State machine with states MANUAL, SCAN and PAUSE, re-evaluated every cycle from the sampled AUTO and HOLD:
  - AUTO=0 → MANUAL.
  - AUTO=1, HOLD=0 → SCAN.
  - AUTO=1, HOLD=1 → PAUSE.
- MANUAL:
  - CH ← SEL, clamped to N-1 when SEL ≥ N.
  - Prescaler is held at 0.
- SCAN:
  - Prescaler counts 0..DIV-1.
  - At DIV-1: prescaler ← 0, CH ← (CH==N-1) ? 0 : CH+1, STEP=1 for that cycle.
  - DIV=1 advances CH every cycle.
- PAUSE: prescaler and CH hold their values. STEP=0.
- MANUAL→SCAN: scanning starts from the current CH with prescaler 0, so the first advance comes DIV cycles later.
- PAUSE→SCAN: the prescaler resumes from its held value.
- Display path:
  - HEX0 ← decode(zero-extended DATA[CH]) every cycle.
  - HEX1 ← decode(CH).
  - Decode is standard DE-board active-low hex 0–F: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 9=0010000, A=0001000, F=0001110.
- Reset values:
  - CH=0, prescaler=0, state=MANUAL, STEP=0.
  - HEX0 and HEX1 = 1111111 (blank).
  - Reset takes effect immediately (asynchronous), including in the middle of a scan.

## Timing
- SEL change → CH updated at the next edge; HEX1 and HEX0 reflect it one edge later (2-cycle latency).
- DATA change on the selected channel → HEX0 updated at the next edge (1 cycle).
- STEP is registered: it is asserted in the same cycle that CH takes its new value. HEX0/HEX1 follow one cycle later.
- AUTO and HOLD take effect at the first edge after they change. No synchroniser is included; the integrator debounces and synchronises them.
- When RESET deasserts, the first edge loads the display registers from CH=0.

## Configuration
- CHSCAN_CHIDX_EN defined: HEX1 displays the decoded CH as described above.
- CHSCAN_CHIDX_EN undefined:
  - HEX1 is constant 1111111 and the HEX1 decode logic is not compiled.
  - All other behaviour is unchanged.

## Test plan
All scenarios use N=4, W=2, DIV=4 unless noted.
- Reset: assert RESET mid-scan → CH=0, STEP=0, HEX0 and HEX1 = 1111111 asynchronously. After release with DATA=8'b11_10_01_00 and AUTO=0, SEL=0 → HEX0=1000000 after 1 edge.
- Manual select: SEL 0→2 with DATA=8'b11_10_01_00 → CH=2 at edge 1; HEX0=0100100 and HEX1=0100100 at edge 2. SEL=3 → HEX0=0110000.
- Auto-scan wrap: AUTO=1 from CH=2 → STEP pulses every 4 cycles; CH sequence 3,0,1 with exactly one STEP cycle per advance.
- Hold: assert HOLD 2 cycles after an advance for 10 cycles → CH constant, no STEP. Release HOLD → next advance exactly 2 cycles later.
- Live data and clamping: with CH=1, change DATA[3:2] 01→10 → HEX0 changes 1111001→0100100 one edge later. Build with N=3, SEL=3 → CH=2. Build with DIV=1 → CH advances and STEP is high every cycle.
- Macro off: build without CHSCAN_CHIDX_EN → HEX1 stays 1111111 through all of the above while HEX0 and CH are unchanged.
